error_check: RTL and testbench

// - UART receive-path frame checker: validates start, stop and parity bits of a

---
 rtl/error_check.sv | 79 +++++++
 tb/tb_error_check.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/error_check.sv
// error_check: UART receive-path frame checker.
// Compares the received start, stop and parity bits against the de-serialised
// data word and registers a 3-bit error vector {stop, start, parity} on every
// clock edge where the receiver reports a completed frame.
// Optional build macro ERR_STICKY_EN: when defined, error bits accumulate
// across frames and clear only on reset; otherwise each qualified edge
// overwrites the vector with the current frame's result.
// PARITY_EN=0 removes the parity logic and ties error_flag[0] to 0.
module error_check #(
  parameter int DATA_BITS = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recieved_flag,
  input  logic                 parity_bit,
  input  logic                 start_bit,
  input  logic                 stop_bit,
  input  logic [1:0]           parity_type,
  input  logic [DATA_BITS-1:0] raw_data,
  output logic [2:0]           error_flag
);

  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  logic       start_err;
  logic       stop_err;
  logic       par_err;
  logic [2:0] new_errors;

  // Framing errors: a legal start bit is 0, a legal stop bit is 1.
  assign start_err  = (start_bit != 1'b0);
  assign stop_err   = (stop_bit  != 1'b1);
  assign new_errors = {stop_err, start_err, par_err};

  generate
    if (PARITY_EN) begin : g_parity
      // XOR chain across the data word; the final tap is the data parity.
      logic [DATA_BITS:0] xor_chain;
      logic               data_parity;

      assign xor_chain[0] = 1'b0;
      for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_xor
        assign xor_chain[gi+1] = xor_chain[gi] ^ raw_data[gi];
      end
      assign data_parity = xor_chain[DATA_BITS];

      // Select the parity rule; codes 00, 11 and any unknown value mean no parity.
      always_comb begin
        par_err = 1'b0;
        case (parity_type)
          PAR_EVEN: par_err = parity_bit ^ data_parity;
          PAR_ODD:  par_err = parity_bit ^ ~data_parity;
          default:  par_err = 1'b0;
        endcase
      end
    end else begin : g_no_parity
      // Parity inputs are intentionally ignored in this build.
      logic unused_parity_inputs;
      assign unused_parity_inputs = ^{parity_bit, parity_type, raw_data};
      assign par_err = 1'b0;
    end
  endgenerate

  // Error vector register: cleared asynchronously, updated only on completed frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_flag <= 3'b000;
    end else if (recieved_flag) begin
`ifdef ERR_STICKY_EN
      error_flag <= error_flag | new_errors;
`else
      error_flag <= new_errors;
`endif
    end
  end

endmodule

// File: tb/tb_error_check.sv
// tb_error_check: randomized and directed self-checking bench for error_check.
// A behavioural model derives the expected error vector from bit counts of the
// frame; a negedge process compares the DUT to it every cycle, and directed
// cases pin both the DUT and the model to hand-computed literals.
module tb_error_check;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          recieved_flag = 1'b0;
  logic          parity_bit = 1'b0;
  logic          start_bit = 1'b0;
  logic          stop_bit = 1'b1;
  logic [1:0]    parity_type = 2'b00;
  logic [DW-1:0] raw_data = '0;
  logic [2:0]    error_flag;

  int       vectors = 0;
  int       miscompares = 0;
  bit       cmp_en = 1'b0;
  logic [2:0] model_flag = 3'b000;

  error_check #(.DATA_BITS(DW), .PARITY_EN(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .recieved_flag (recieved_flag),
    .parity_bit    (parity_bit),
    .start_bit     (start_bit),
    .stop_bit      (stop_bit),
    .parity_type   (parity_type),
    .raw_data      (raw_data),
    .error_flag    (error_flag)
  );

  always #5 clk = ~clk;

  // Expected errors of one frame, from the count of ones in data plus parity bit.
  function automatic logic [2:0] frame_errors(input logic pb, input logic sb,
                                              input logic stb, input logic [1:0] pt,
                                              input logic [DW-1:0] data);
    int   total;
    logic pe;
    total = $countones(data) + (pb === 1'b1 ? 1 : 0);
    pe = 1'b0;
    if (pt === 2'b10) pe = (total % 2) != 0;   // even: total ones must be even
    if (pt === 2'b01) pe = (total % 2) == 0;   // odd: total ones must be odd
    return {stb !== 1'b1, sb !== 1'b0, pe};
  endfunction

  // Reference model of the registered error vector.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_flag = 3'b000;
    end else if (recieved_flag) begin
`ifdef ERR_STICKY_EN
      model_flag = model_flag | frame_errors(parity_bit, start_bit, stop_bit, parity_type, raw_data);
`else
      model_flag = frame_errors(parity_bit, start_bit, stop_bit, parity_type, raw_data);
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (error_flag !== model_flag) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t got=%b expected=%b", $time, error_flag, model_flag);
      end
    end
  end

  // Literal expectation: checks the DUT and the model against a hand value.
  task automatic check_lit(input string name, input logic [2:0] want);
    vectors++;
    if (error_flag !== want) begin
      miscompares++;
      $display("FAIL %s dut got=%b expected=%b", name, error_flag, want);
    end
    vectors++;
    if (model_flag !== want) begin
      miscompares++;
      $display("FAIL %s model got=%b expected=%b", name, model_flag, want);
    end
    $display("case %s: error_flag=%b", name, error_flag);
  endtask

  // Drive one frame's inputs, then move to just after the next rising edge.
  task automatic frame(input logic rf, input logic [1:0] pt, input logic pb,
                       input logic sb, input logic stb, input logic [DW-1:0] data);
    recieved_flag = rf;
    parity_type   = pt;
    parity_bit    = pb;
    start_bit     = sb;
    stop_bit      = stb;
    raw_data      = data;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sticky builds need a clean vector before each independent directed case.
  task automatic maybe_reset();
`ifdef ERR_STICKY_EN
    pulse_reset();
`endif
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check_lit("reset_state", 3'b000);
    reset = 1'b0;

    // Directed cases.
    frame(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h55);
    check_lit("c1_even_ok", 3'b000);
    maybe_reset();
    frame(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 8'h55);
    check_lit("c2_even_bad", 3'b001);
    maybe_reset();
    frame(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h55);
    check_lit("c3_par_start", 3'b011);
    maybe_reset();
    frame(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 8'h55);
    check_lit("c4_par_stop", 3'b101);
    maybe_reset();
    frame(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h55);
    check_lit("c5_start_stop", 3'b110);
    maybe_reset();
    frame(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h55);
    check_lit("c6_odd_ok", 3'b000);
    frame(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h07);
    check_lit("odd_weight_even", 3'b001);
    maybe_reset();
    frame(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h55);
    check_lit("c7_none_pb1", 3'b000);
    frame(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'h55);
    check_lit("c7_none_pb0", 3'b000);
    frame(1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 8'h54);
    check_lit("none_code11", 3'b000);
    frame(1'b1, 2'bxx, 1'b1, 1'b0, 1'b1, 8'h55);
    check_lit("ptype_unknown", 3'b000);
    maybe_reset();
    frame(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h55);
    check_lit("c8_setup", 3'b110);
    frame(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 8'h55);
    check_lit("c8_hold_a", 3'b110);
    frame(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00);
    check_lit("c8_hold_b", 3'b110);

    // Reset asserted mid-cycle clears the output at once.
    frame(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h55);
    check_lit("c9_setup", 3'b111);
    #2;
    reset = 1'b1;
    #1;
    check_lit("c9_async_reset", 3'b000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame(1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 8'h55);
    check_lit("c9_no_eval_rf0", 3'b000);
    frame(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h55);
    check_lit("c9_first_eval", 3'b111);

`ifdef ERR_STICKY_EN
    pulse_reset();
    frame(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h55);
    check_lit("c10_sticky_set", 3'b011);
    frame(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h55);
    check_lit("c10_sticky_keep", 3'b011);
    frame(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h55);
    check_lit("c10_sticky_keep2", 3'b011);
    pulse_reset();
    check_lit("c10_sticky_clear", 3'b000);
`endif

    // Random sweep over all parity codes with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      frame($urandom_range(0, 9) < 7,
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0,
            DW'($urandom));
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
